// File: rtl/uart_cmd_sched_if.sv
// UART-side handshake bundle for uart_cmd_sched: RX byte strobe in, TX start/data out.
// The master modport is the scheduler; the slave modport is the UART RX/TX pair.
interface uart_cmd_sched_if;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic       i_tx_busy;
  logic       o_tx_start;
  logic [7:0] o_tx_data;

  modport master (
    input  i_rx_data,
    input  i_rx_done,
    input  i_tx_busy,
    output o_tx_start,
    output o_tx_data
  );

  modport slave (
    output i_rx_data,
    output i_rx_done,
    output i_tx_busy,
    input  o_tx_start,
    input  o_tx_data
  );
endinterface

// File: rtl/uart_cmd_sched.sv
// Merges UART-decoded navigation commands with button pulses (buttons win) and
// streams an ASCII time report "HH:MM:SS.CC\r\n" through the UART TX handshake.
module uart_cmd_sched #(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter logic [7:0]  CMD_UP      = 8'h55,
  parameter logic [7:0]  CMD_DOWN    = 8'h44,
  parameter logic [7:0]  CMD_LEFT    = 8'h4C,
  parameter logic [7:0]  CMD_RIGHT   = 8'h52,
  parameter logic [7:0]  CMD_REPORT  = 8'h54
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_btn_up,
  input  logic                   i_btn_down,
  input  logic                   i_btn_left,
  input  logic                   i_btn_right,
  input  logic [4:0]             i_hour,
  input  logic [5:0]             i_min,
  input  logic [5:0]             i_sec,
  input  logic [6:0]             i_msec,
  uart_cmd_sched_if.master       uart,
  output logic                   o_up,
  output logic                   o_down,
  output logic                   o_left,
  output logic                   o_right,
  output logic                   o_drop,
  output logic                   o_report_busy
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_ACK, WAIT_DONE} state_t;

  function automatic logic is_cmd(input logic [7:0] b, input logic [7:0] c);
    return (b == c) || (b == (c | 8'h20));
  endfunction

  function automatic logic [7:0] ascii_digit(input logic [6:0] v, input logic tens);
    logic [6:0] d;
    d = tens ? (v / 7'd10) : (v % 7'd10);
    return 8'h30 + {1'b0, d};
  endfunction

  function automatic logic [7:0] frame_byte(input logic [3:0] i, input logic [6:0] h,
                                            input logic [6:0] m, input logic [6:0] s,
                                            input logic [6:0] c);
    logic [7:0] b;
    case (i)
      4'd0:    b = ascii_digit(h, 1'b1);
      4'd1:    b = ascii_digit(h, 1'b0);
      4'd2:    b = 8'h3A;
      4'd3:    b = ascii_digit(m, 1'b1);
      4'd4:    b = ascii_digit(m, 1'b0);
      4'd5:    b = 8'h3A;
      4'd6:    b = ascii_digit(s, 1'b1);
      4'd7:    b = ascii_digit(s, 1'b0);
      4'd8:    b = 8'h2E;
      4'd9:    b = ascii_digit(c, 1'b1);
      4'd10:   b = ascii_digit(c, 1'b0);
      4'd11:   b = 8'h0D;
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

  // Command vectors are ordered {up, down, left, right}.
  logic [3:0] btn_vec;
  logic [3:0] nav_req;
  logic       rpt_req;
  logic [3:0] nav_out;
  logic       pend_vld;
  logic [3:0] pend_cmd;
  logic       pend_set;
  logic       pend_clr;
  logic       drop_nav;

  assign btn_vec = {i_btn_up, i_btn_down, i_btn_left, i_btn_right};
  assign nav_req = uart.i_rx_done ? {is_cmd(uart.i_rx_data, CMD_UP),
                                     is_cmd(uart.i_rx_data, CMD_DOWN),
                                     is_cmd(uart.i_rx_data, CMD_LEFT),
                                     is_cmd(uart.i_rx_data, CMD_RIGHT)} : 4'b0000;
  assign rpt_req = uart.i_rx_done && is_cmd(uart.i_rx_data, CMD_REPORT);

  always_comb begin
    nav_out  = 4'b0000;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    drop_nav = 1'b0;
    if (btn_vec != 4'b0000) begin
      nav_out = btn_vec;
      if (nav_req != 4'b0000) begin
        if (pend_vld) drop_nav = 1'b1;
        else          pend_set = 1'b1;
      end
    end else if (pend_vld) begin
      // Pending goes out first; a same-cycle fresh request takes the freed slot.
      nav_out  = pend_cmd;
      pend_clr = 1'b1;
      if (nav_req != 4'b0000) pend_set = 1'b1;
    end else begin
      nav_out = nav_req;
    end
  end

  assign {o_up, o_down, o_left, o_right} = reset ? nav_out : 4'b0000;
  assign o_drop = reset && (drop_nav || (rpt_req && o_report_busy));

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_vld <= 1'b0;
      pend_cmd <= 4'b0000;
    end else if (pend_set) begin
      pend_vld <= 1'b1;
      pend_cmd <= nav_req;
    end else if (pend_clr) begin
      pend_vld <= 1'b0;
    end
  end

  state_t           state;
  logic [3:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       snap_h;
  logic [6:0]       snap_m;
  logic [6:0]       snap_s;
  logic [6:0]       snap_c;

  always_ff @(posedge clk) begin
    if (rpt_req && state == IDLE) begin
      snap_h <= 7'(i_hour);
      snap_m <= 7'(i_min);
      snap_s <= 7'(i_sec);
      snap_c <= i_msec;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      idx             <= 4'd0;
      cnt             <= '0;
      uart.o_tx_start <= 1'b0;
      uart.o_tx_data  <= 8'h00;
      o_report_busy   <= 1'b0;
    end else begin
      uart.o_tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (rpt_req) begin
            idx           <= 4'd0;
            o_report_busy <= 1'b1;
            state         <= LOAD;
          end
        end
        LOAD: begin
          uart.o_tx_data <= frame_byte(idx, snap_h, snap_m, snap_s, snap_c);
          state          <= START;
        end
        START: begin
          if (!uart.i_tx_busy) begin
            uart.o_tx_start <= 1'b1;
            cnt             <= '0;
            state           <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (uart.i_tx_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
            // No acknowledge from the transmitter: count the byte as sent.
            idx <= idx + 4'd1;
            if (idx == 4'd12) begin
              state         <= IDLE;
              o_report_busy <= 1'b0;
            end else begin
              state <= LOAD;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!uart.i_tx_busy) begin
            idx <= idx + 4'd1;
            if (idx == 4'd12) begin
              state         <= IDLE;
              o_report_busy <= 1'b0;
            end else begin
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
